// File: rtl/m_wbone_arbiter.sv
// m_wbone_arbiter: two-master round-robin Wishbone arbiter with CYC bus lock
// and a per-access watchdog that answers hung strobes with ERR.
module m_wbone_arbiter #(
   parameter int TIMEOUT                = 100,
   parameter bit DAT_ZERO_WHEN_INACTIVE = 1'b1
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        m0_CYC_I,
   input  logic        m0_STB_I,
   input  logic        m0_WE_I,
   input  logic [31:0] m0_ADR_I,
   input  logic [31:0] m0_DAT_I,
   input  logic [3:0]  m0_SEL_I,
   output logic        m0_ACK_O,
   output logic        m0_ERR_O,
   output logic [31:0] m0_DAT_O,
   input  logic        m1_CYC_I,
   input  logic        m1_STB_I,
   input  logic        m1_WE_I,
   input  logic [31:0] m1_ADR_I,
   input  logic [31:0] m1_DAT_I,
   input  logic [3:0]  m1_SEL_I,
   output logic        m1_ACK_O,
   output logic        m1_ERR_O,
   output logic [31:0] m1_DAT_O,
   output logic        s_CYC_O,
   output logic        s_STB_O,
   output logic        s_WE_O,
   output logic [31:0] s_ADR_O,
   output logic [31:0] s_DAT_O,
   output logic [3:0]  s_SEL_O,
   input  logic        s_ACK_I,
   input  logic [31:0] s_DAT_I,
   output logic [1:0]  gnt,
   output logic [7:0]  errcnt
);
   typedef enum logic [2:0] {IDLE, GNT0, GNT1, TERR0, TERR1} state_t;
   state_t     state;
   logic       last;
   logic [7:0] wd;
   logic       own, act, cyc, stb, fire;
   assign own  = state == GNT1 || state == TERR1;
   assign act  = state == GNT0 || state == GNT1;
   assign cyc  = own ? m1_CYC_I : m0_CYC_I;
   assign stb  = own ? m1_STB_I : m0_STB_I;
   assign fire = stb && !s_ACK_I && wd == 8'(TIMEOUT - 1);
   assign s_CYC_O  = act && cyc;
   assign s_STB_O  = act && stb;
   assign s_WE_O   = act && (own ? m1_WE_I : m0_WE_I);
   assign s_ADR_O  = act ? (own ? m1_ADR_I : m0_ADR_I) : '0;
   assign s_DAT_O  = act ? (own ? m1_DAT_I : m0_DAT_I) : '0;
   assign s_SEL_O  = act ? (own ? m1_SEL_I : m0_SEL_I) : '0;
   assign m0_ACK_O = state == GNT0 && s_ACK_I;
   assign m1_ACK_O = state == GNT1 && s_ACK_I;
   assign m0_ERR_O = state == TERR0;
   assign m1_ERR_O = state == TERR1;
   assign m0_DAT_O = (!DAT_ZERO_WHEN_INACTIVE || m0_ACK_O) ? s_DAT_I : '0;
   assign m1_DAT_O = (!DAT_ZERO_WHEN_INACTIVE || m1_ACK_O) ? s_DAT_I : '0;
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state  <= IDLE;
         last   <= 1'b1;
         gnt    <= 2'b00;
         wd     <= '0;
         errcnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               wd <= '0;
               // on a tie the master that did not own the bus last wins
               if (m0_CYC_I && (!m1_CYC_I || last)) begin
                  state <= GNT0;
                  gnt   <= 2'b01;
                  last  <= 1'b0;
               end else if (m1_CYC_I) begin
                  state <= GNT1;
                  gnt   <= 2'b10;
                  last  <= 1'b1;
               end
            end
            GNT0, GNT1: begin
               if (!cyc) begin
                  state <= IDLE;
                  gnt   <= 2'b00;
                  wd    <= '0;
               end else if (fire) begin
                  state <= own ? TERR1 : TERR0;
                  wd    <= '0;
               end else begin
                  wd <= (s_ACK_I || !stb) ? '0 : wd + 8'd1;
               end
            end
            default: begin
               errcnt <= errcnt + {7'd0, errcnt != 8'hff};
               wd     <= '0;
               if (cyc) begin
                  state <= own ? GNT1 : GNT0;
               end else begin
                  state <= IDLE;
                  gnt   <= 2'b00;
               end
            end
         endcase
      end
   end
endmodule
